// File: rtl/vchannel_fifo_bank_pkg.sv
// Shared constants for the virtual-channel buffer bank: channel count and
// channel IDs, encoded the same way as the downstream arbiter's priority table.
package vchannel_fifo_bank_pkg;

    localparam int NUM_VC = 4;

    typedef logic [1:0] vc_id_t;

    localparam vc_id_t VCHANEL0 = 2'b00;
    localparam vc_id_t VCHANEL1 = 2'b01;
    localparam vc_id_t VCHANEL2 = 2'b10;
    localparam vc_id_t VCHANEL3 = 2'b11;

    // Occupancy needed for DEPTH entries plus the zero state.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vchannel_fifo_bank_fifo.sv
// Single first-word-fall-through FIFO channel. Head is read straight out of
// the storage array; status decodes from the registered occupancy count.
module vc_fifo
    import vchannel_fifo_bank_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3
) (
    input  logic              clk0,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              ovf,
    output logic              unf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rd_ok;
    logic              wr_ok;

    // A pop on a full channel frees a slot in the same cycle, so the write
    // may land even when count equals DEPTH.
    always_comb begin
        rd_ok = rd_en && (count_q != '0);
        wr_ok = wr_en && ((count_q < CNT_W'(DEPTH)) || rd_ok);
        ovf   = wr_en && !wr_ok;
        unf   = rd_en && !rd_ok;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        rd_data     = mem_q[rd_ptr_q];
        empty       = (count_q == '0);
        full        = (count_q == CNT_W'(DEPTH));
        almost_full = (count_q >= CNT_W'(AF_THRESH));
    end

endmodule

// File: rtl/vchannel_fifo_bank.sv
// Four independent virtual-channel FIFOs feeding the weighted round-robin
// arbiter: steers writes by channel ID and collects sticky error flags.
module vchannel_fifo_bank
    import vchannel_fifo_bank_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3
) (
    input  logic              clk0,
    input  logic              rst,
    input  logic              enb,
    input  logic              push,
    input  logic [1:0]        push_vc,
    input  logic [DATA_W-1:0] push_data,
    input  logic [3:0]        pop,
    output logic [DATA_W-1:0] data_vchannel0,
    output logic [DATA_W-1:0] data_vchannel1,
    output logic [DATA_W-1:0] data_vchannel2,
    output logic [DATA_W-1:0] data_vchannel3,
    output logic              empty_vchannel0,
    output logic              empty_vchannel1,
    output logic              empty_vchannel2,
    output logic              empty_vchannel3,
    output logic              full_vchannel0,
    output logic              full_vchannel1,
    output logic              full_vchannel2,
    output logic              full_vchannel3,
    output logic              almost_full_vchannel0,
    output logic              almost_full_vchannel1,
    output logic              almost_full_vchannel2,
    output logic              almost_full_vchannel3,
    output logic              overflow_err,
    output logic              underflow_err
);

    logic [NUM_VC-1:0] wr_en_vec;
    logic [NUM_VC-1:0] rd_en_vec;
    logic [NUM_VC-1:0] empty_vec;
    logic [NUM_VC-1:0] full_vec;
    logic [NUM_VC-1:0] af_vec;
    logic [NUM_VC-1:0] ovf_vec;
    logic [NUM_VC-1:0] unf_vec;
    logic [DATA_W-1:0] rd_data_vec [NUM_VC];
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    always_comb begin
        wr_en_vec = '0;
        if (enb && push) begin
            case (push_vc)
                VCHANEL0: wr_en_vec[0] = 1'b1;
                VCHANEL1: wr_en_vec[1] = 1'b1;
                VCHANEL2: wr_en_vec[2] = 1'b1;
                VCHANEL3: wr_en_vec[3] = 1'b1;
            endcase
        end
        rd_en_vec = pop & {NUM_VC{enb}};
    end

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        vc_fifo #(
            .DATA_W    (DATA_W),
            .DEPTH     (DEPTH),
            .AF_THRESH (AF_THRESH)
        ) u_fifo (
            .clk0        (clk0),
            .rst         (rst),
            .wr_en       (wr_en_vec[g]),
            .wr_data     (push_data),
            .rd_en       (rd_en_vec[g]),
            .rd_data     (rd_data_vec[g]),
            .empty       (empty_vec[g]),
            .full        (full_vec[g]),
            .almost_full (af_vec[g]),
            .ovf         (ovf_vec[g]),
            .unf         (unf_vec[g])
        );
    end

    // Error events are already qualified by enb inside the enables.
    always_comb begin
        overflow_d  = overflow_q  | (|ovf_vec);
        underflow_d = underflow_q | (|unf_vec);
    end

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

    assign data_vchannel0 = rd_data_vec[0];
    assign data_vchannel1 = rd_data_vec[1];
    assign data_vchannel2 = rd_data_vec[2];
    assign data_vchannel3 = rd_data_vec[3];

    assign empty_vchannel0 = empty_vec[0];
    assign empty_vchannel1 = empty_vec[1];
    assign empty_vchannel2 = empty_vec[2];
    assign empty_vchannel3 = empty_vec[3];

    assign full_vchannel0 = full_vec[0];
    assign full_vchannel1 = full_vec[1];
    assign full_vchannel2 = full_vec[2];
    assign full_vchannel3 = full_vec[3];

    assign almost_full_vchannel0 = af_vec[0];
    assign almost_full_vchannel1 = af_vec[1];
    assign almost_full_vchannel2 = af_vec[2];
    assign almost_full_vchannel3 = af_vec[3];

endmodule

// File: tb/tb_vchannel_fifo_bank.sv
// Bench for vchannel_fifo_bank: a queue-per-channel reference model holds the
// expected contents; each test task compares DUT heads and flags against it.
module tb_vchannel_fifo_bank;

    logic       clk0;
    logic       rst;
    logic       enb;
    logic       push;
    logic [1:0] push_vc;
    logic [3:0] push_data;
    logic [3:0] pop;
    logic [3:0] data_vchannel0, data_vchannel1, data_vchannel2, data_vchannel3;
    logic       empty_vchannel0, empty_vchannel1, empty_vchannel2, empty_vchannel3;
    logic       full_vchannel0, full_vchannel1, full_vchannel2, full_vchannel3;
    logic       almost_full_vchannel0, almost_full_vchannel1;
    logic       almost_full_vchannel2, almost_full_vchannel3;
    logic       overflow_err, underflow_err;

    logic [3:0] exp_q [4][$];
    logic       exp_ovf;
    logic       exp_unf;
    int         total;
    int         bad;

    vchannel_fifo_bank #(.DATA_W(4), .DEPTH(4), .AF_THRESH(3)) dut (
        .clk0(clk0), .rst(rst), .enb(enb), .push(push), .push_vc(push_vc),
        .push_data(push_data), .pop(pop),
        .data_vchannel0(data_vchannel0), .data_vchannel1(data_vchannel1),
        .data_vchannel2(data_vchannel2), .data_vchannel3(data_vchannel3),
        .empty_vchannel0(empty_vchannel0), .empty_vchannel1(empty_vchannel1),
        .empty_vchannel2(empty_vchannel2), .empty_vchannel3(empty_vchannel3),
        .full_vchannel0(full_vchannel0), .full_vchannel1(full_vchannel1),
        .full_vchannel2(full_vchannel2), .full_vchannel3(full_vchannel3),
        .almost_full_vchannel0(almost_full_vchannel0),
        .almost_full_vchannel1(almost_full_vchannel1),
        .almost_full_vchannel2(almost_full_vchannel2),
        .almost_full_vchannel3(almost_full_vchannel3),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    // clock / reset
    initial begin
        clk0 = 1'b0;
        forever #5 clk0 = ~clk0;
    end

    function automatic logic [3:0] get_data(input int n);
        case (n)
            0:       return data_vchannel0;
            1:       return data_vchannel1;
            2:       return data_vchannel2;
            default: return data_vchannel3;
        endcase
    endfunction

    // {empty, full, almost_full} observed on channel n
    function automatic logic [2:0] get_flags(input int n);
        case (n)
            0:       return {empty_vchannel0, full_vchannel0, almost_full_vchannel0};
            1:       return {empty_vchannel1, full_vchannel1, almost_full_vchannel1};
            2:       return {empty_vchannel2, full_vchannel2, almost_full_vchannel2};
            default: return {empty_vchannel3, full_vchannel3, almost_full_vchannel3};
        endcase
    endfunction

    function automatic logic [2:0] exp_flags(input int n);
        int sz;
        sz = exp_q[n].size();
        return {sz == 0, sz == 4, sz >= 3};
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 4; n++) exp_q[n].delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
    endtask

    // driver: applies one cycle of stimulus, updates the model, advances past the edge
    task automatic drive_cycle(input logic e, input logic p, input logic [1:0] vc,
                               input logic [3:0] d, input logic [3:0] pp);
        enb = e; push = p; push_vc = vc; push_data = d; pop = pp;
        for (int n = 0; n < 4; n++) begin
            logic wr, rd, rd_ok, wr_ok;
            wr    = e && p && (int'(vc) == n);
            rd    = e && pp[n];
            rd_ok = rd && (exp_q[n].size() > 0);
            wr_ok = wr && ((exp_q[n].size() < 4) || rd_ok);
            if (rd_ok) void'(exp_q[n].pop_front());
            if (wr_ok) exp_q[n].push_back(d);
            if (wr && !wr_ok) exp_ovf = 1'b1;
            if (rd && !rd_ok) exp_unf = 1'b1;
        end
        @(posedge clk0);
        #1;
        enb = 1'b1; push = 1'b0; pop = 4'b0000;
    endtask

    task automatic apply_reset();
        #2 rst = 1'b1;
        model_reset();
        #2 rst = 1'b0;
        @(posedge clk0);
        #1;
    endtask

    task automatic test_reset();
        enb = 1'b1; push = 1'b0; push_vc = 2'd0; push_data = 4'h0; pop = 4'b0000;
        rst = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int n = 0; n < 4; n++) begin
            total++;
            if (get_flags(n) !== 3'b100) begin
                bad++; $display("FAIL reset_flags ch%0d got=%b want=100", n, get_flags(n));
            end
            total++;
            if (get_data(n) !== 4'h0) begin
                bad++; $display("FAIL reset_data ch%0d got=%h want=0", n, get_data(n));
            end
        end
        total++;
        if ({overflow_err, underflow_err} !== 2'b00) begin
            bad++; $display("FAIL reset_err got=%b want=00", {overflow_err, underflow_err});
        end
        #3 rst = 1'b0;
        @(posedge clk0);
        #1;
        for (int c = 0; c < 5; c++) drive_cycle(1'b1, 1'b0, 2'd0, 4'h0, 4'b0000);
        for (int n = 0; n < 4; n++) begin
            total++;
            if (get_flags(n) !== 3'b100 || get_data(n) !== 4'h0) begin
                bad++; $display("FAIL idle ch%0d got=%b/%h want=100/0", n, get_flags(n), get_data(n));
            end
        end
    endtask

    task automatic test_steering();
        drive_cycle(1'b1, 1'b1, 2'd2, 4'hc, 4'b0000);
        total++;
        if (data_vchannel2 !== 4'hc || empty_vchannel2 !== 1'b0) begin
            bad++; $display("FAIL steer_vc2 got=%h/%b want=c/0", data_vchannel2, empty_vchannel2);
        end
        drive_cycle(1'b1, 1'b1, 2'd0, 4'ha, 4'b0000);
        for (int n = 0; n < 4; n++) begin
            total++;
            if (get_flags(n) !== exp_flags(n)) begin
                bad++; $display("FAIL steer_flags ch%0d got=%b want=%b", n, get_flags(n), exp_flags(n));
            end
            if (exp_q[n].size() > 0) begin
                total++;
                if (get_data(n) !== exp_q[n][0]) begin
                    bad++; $display("FAIL steer_head ch%0d got=%h want=%h", n, get_data(n), exp_q[n][0]);
                end
            end
        end
        drive_cycle(1'b1, 1'b0, 2'd0, 4'h0, 4'b0101);
        total++;
        if ({empty_vchannel0, empty_vchannel2} !== 2'b11) begin
            bad++; $display("FAIL steer_drain got=%b want=11", {empty_vchannel0, empty_vchannel2});
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= 4; i++) begin
            drive_cycle(1'b1, 1'b1, 2'd1, 4'(i), 4'b0000);
            total++;
            if (get_flags(1) !== exp_flags(1)) begin
                bad++; $display("FAIL fill_flags n=%0d got=%b want=%b", i, get_flags(1), exp_flags(1));
            end
        end
        total++;
        if ({full_vchannel1, almost_full_vchannel1} !== 2'b11) begin
            bad++; $display("FAIL fill_full got=%b want=11", {full_vchannel1, almost_full_vchannel1});
        end
        drive_cycle(1'b1, 1'b1, 2'd1, 4'h5, 4'b0000);
        total++;
        if (overflow_err !== exp_ovf || overflow_err !== 1'b1) begin
            bad++; $display("FAIL ovf_set got=%b want=1", overflow_err);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (empty_vchannel1 !== 1'b0 || data_vchannel1 !== exp_q[1][0]) begin
                bad++; $display("FAIL ovf_drain i=%0d got=%h want=%h", i, data_vchannel1, exp_q[1][0]);
            end
            drive_cycle(1'b1, 1'b0, 2'd0, 4'h0, 4'b0010);
        end
        total++;
        if (empty_vchannel1 !== 1'b1 || underflow_err !== 1'b0) begin
            bad++; $display("FAIL ovf_empty got=%b/%b want=1/0", empty_vchannel1, underflow_err);
        end
    endtask

    task automatic test_push_pop_full();
        apply_reset();
        drive_cycle(1'b1, 1'b1, 2'd3, 4'h9, 4'b0000);
        drive_cycle(1'b1, 1'b1, 2'd3, 4'ha, 4'b0000);
        drive_cycle(1'b1, 1'b1, 2'd3, 4'hb, 4'b0000);
        drive_cycle(1'b1, 1'b1, 2'd3, 4'hc, 4'b0000);
        drive_cycle(1'b1, 1'b1, 2'd3, 4'hd, 4'b1000);
        total++;
        if (full_vchannel3 !== 1'b1 || data_vchannel3 !== 4'ha || overflow_err !== 1'b0) begin
            bad++; $display("FAIL pp_full got=%b/%h/%b want=1/a/0", full_vchannel3, data_vchannel3, overflow_err);
        end
        while (exp_q[3].size() > 0) begin
            total++;
            if (data_vchannel3 !== exp_q[3][0]) begin
                bad++; $display("FAIL pp_drain got=%h want=%h", data_vchannel3, exp_q[3][0]);
            end
            drive_cycle(1'b1, 1'b0, 2'd0, 4'h0, 4'b1000);
        end
        total++;
        if (empty_vchannel3 !== 1'b1) begin
            bad++; $display("FAIL pp_empty got=%b want=1", empty_vchannel3);
        end
    endtask

    task automatic test_underflow_multihot();
        drive_cycle(1'b1, 1'b0, 2'd0, 4'h0, 4'b1111);
        total++;
        if (underflow_err !== 1'b1 || overflow_err !== 1'b0) begin
            bad++; $display("FAIL unf_set got=%b/%b want=1/0", underflow_err, overflow_err);
        end
        drive_cycle(1'b1, 1'b1, 2'd0, 4'h1, 4'b0000);
        drive_cycle(1'b1, 1'b1, 2'd3, 4'h2, 4'b0000);
        total++;
        if (data_vchannel0 !== 4'h1 || data_vchannel3 !== 4'h2) begin
            bad++; $display("FAIL mh_load got=%h/%h want=1/2", data_vchannel0, data_vchannel3);
        end
        drive_cycle(1'b1, 1'b0, 2'd0, 4'h0, 4'b1001);
        for (int n = 0; n < 4; n++) begin
            total++;
            if (get_flags(n) !== exp_flags(n)) begin
                bad++; $display("FAIL mh_flags ch%0d got=%b want=%b", n, get_flags(n), exp_flags(n));
            end
        end
    endtask

    task automatic test_enable_hold();
        apply_reset();
        drive_cycle(1'b1, 1'b1, 2'd2, 4'h5, 4'b0000);
        for (int c = 0; c < 4; c++) begin
            drive_cycle(1'b0, 1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'b1111);
        end
        for (int n = 0; n < 4; n++) begin
            total++;
            if (get_flags(n) !== exp_flags(n)) begin
                bad++; $display("FAIL enb_flags ch%0d got=%b want=%b", n, get_flags(n), exp_flags(n));
            end
        end
        total++;
        if (data_vchannel2 !== 4'h5 || {overflow_err, underflow_err} !== 2'b00) begin
            bad++; $display("FAIL enb_hold got=%h/%b want=5/00", data_vchannel2, {overflow_err, underflow_err});
        end
    endtask

    task automatic test_reset_midop();
        drive_cycle(1'b1, 1'b1, 2'd0, 4'h3, 4'b0000);
        drive_cycle(1'b1, 1'b1, 2'd0, 4'h4, 4'b0000);
        #2 rst = 1'b1;
        model_reset();
        #1;
        total++;
        if (empty_vchannel0 !== 1'b1 || data_vchannel0 !== 4'h0 || empty_vchannel2 !== 1'b1) begin
            bad++; $display("FAIL midrst got=%b/%h/%b want=1/0/1", empty_vchannel0, data_vchannel0, empty_vchannel2);
        end
        #2 rst = 1'b0;
        @(posedge clk0);
        #1;
        drive_cycle(1'b1, 1'b1, 2'd0, 4'h7, 4'b0000);
        total++;
        if (empty_vchannel0 !== 1'b0 || data_vchannel0 !== exp_q[0][0]) begin
            bad++; $display("FAIL post_rst got=%b/%h want=0/%h", empty_vchannel0, data_vchannel0, exp_q[0][0]);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int c = 0; c < 40; c++) begin
            drive_cycle(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            for (int n = 0; n < 4; n++) begin
                total++;
                if (get_flags(n) !== exp_flags(n)) begin
                    bad++; $display("FAIL b2b_flags c=%0d ch%0d got=%b want=%b", c, n, get_flags(n), exp_flags(n));
                end
                if (exp_q[n].size() > 0) begin
                    total++;
                    if (get_data(n) !== exp_q[n][0]) begin
                        bad++; $display("FAIL b2b_head c=%0d ch%0d got=%h want=%h", c, n, get_data(n), exp_q[n][0]);
                    end
                end
            end
            total++;
            if ({overflow_err, underflow_err} !== {exp_ovf, exp_unf}) begin
                bad++; $display("FAIL b2b_err c=%0d got=%b want=%b", c, {overflow_err, underflow_err}, {exp_ovf, exp_unf});
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_steering();
        test_fill_overflow();
        test_push_pop_full();
        test_underflow_multihot();
        test_enable_hold();
        test_reset_midop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
